// File: rtl/matrix_mac_engine_pkg.sv
// matrix_mac_engine_pkg: shared state encoding, width helpers and readout clamp
package matrix_mac_engine_pkg;

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_COMPUTE,
        S_DONE,
        S_RESULT
    } state_t;

    localparam int DECIMAL_CLAMP = 9;

    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int idx_width(input int n);
        return $clog2(2 * n * n);
    endfunction

    function automatic int sel_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_mac_unit.sv
// matrix_mac_unit: unsigned DW x DW multiplier feeding an ACCW accumulator
module matrix_mac_unit #(
    parameter int DW   = 4,
    parameter int ACCW = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic            first,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] sum
);

    logic [2*DW-1:0] prod;
    logic [ACCW-1:0] acc_q, acc_d;

    assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

    // first term loads the product, later terms add to the running sum
    always_comb begin
        sum   = first ? ACCW'(prod) : acc_q + ACCW'(prod);
        acc_d = clr ? '0 : (en ? sum : acc_q);
    end

    // accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

endmodule

// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: NxN unsigned matrix multiply with serial operand load and one MAC
module matrix_mac_engine
    import matrix_mac_engine_pkg::*;
#(
    parameter int N    = 2,
    parameter int DW   = 4,
    parameter int ACCW = acc_width(N, DW)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      load_valid,
    input  logic [DW-1:0]             load_data,
    output logic                      load_ready,
    output logic [idx_width(N)-1:0]   load_idx,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      result_valid,
    input  logic [sel_width(N)-1:0]   rd_row,
    input  logic [sel_width(N)-1:0]   rd_col,
    output logic [ACCW-1:0]           rd_data,
    output logic [3:0]                rd_digit
);

    localparam int IW = idx_width(N);
    localparam int RW = sel_width(N);
    localparam int NN = N * N;

    state_t          state_q, state_d;
    logic [IW-1:0]   load_idx_q, load_idx_d;
    logic [RW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DW-1:0]   a_q [NN];
    logic [DW-1:0]   a_d [NN];
    logic [DW-1:0]   b_q [NN];
    logic [DW-1:0]   b_d [NN];
    logic [ACCW-1:0] c_q [NN];
    logic [ACCW-1:0] c_d [NN];
    logic [DW-1:0]   a_op, b_op;
    logic [ACCW-1:0] mac_sum;
    logic            mac_en, mac_first;

    assign load_ready   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign busy         = state_q == S_COMPUTE;
    assign done         = state_q == S_DONE;
    assign result_valid = state_q == S_RESULT;
    assign load_idx     = load_idx_q;
    assign mac_en       = busy;
    assign mac_first    = k_q == '0;
    assign rd_digit     = (rd_data > ACCW'(DECIMAL_CLAMP)) ? 4'(DECIMAL_CLAMP) : rd_data[3:0];

    // pick A[i][k] and B[k][j] for the current MAC step
    always_comb begin
        a_op = '0;
        b_op = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (i_q == RW'(r) && k_q == RW'(c)) a_op = a_q[r*N+c];
                if (k_q == RW'(r) && j_q == RW'(c)) b_op = b_q[r*N+c];
            end
    end

    // combinational random-access readout of C
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (rd_row == RW'(r) && rd_col == RW'(c)) rd_data = c_q[r*N+c];
    end

    // FSM next state, load/loop counters and register file updates; clear wins over all
    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        if (clear) begin
            state_d    = S_LOAD_A;
            load_idx_d = '0;
            i_d        = '0;
            j_d        = '0;
            k_d        = '0;
            for (int e = 0; e < NN; e++) begin
                a_d[e] = '0;
                b_d[e] = '0;
                c_d[e] = '0;
            end
        end else begin
            case (state_q)
                S_LOAD_A, S_LOAD_B: begin
                    if (load_valid) begin
                        for (int e = 0; e < NN; e++) begin
                            if (load_idx_q == IW'(e))      a_d[e] = load_data;
                            if (load_idx_q == IW'(NN + e)) b_d[e] = load_data;
                        end
                        load_idx_d = load_idx_q + IW'(1);
                        if (load_idx_q == IW'(NN - 1)) state_d = S_LOAD_B;
                        if (load_idx_q == IW'(2*NN - 1)) begin
                            state_d    = S_WAIT;
                            load_idx_d = '0;
                        end
                    end
                end
                S_WAIT, S_RESULT: begin
                    if (start) begin
                        state_d = S_COMPUTE;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                    end
                end
                S_COMPUTE: begin
                    k_d = k_q + RW'(1);
                    if (k_q == RW'(N - 1)) begin
                        k_d = '0;
                        for (int r = 0; r < N; r++)
                            for (int c = 0; c < N; c++)
                                if (i_q == RW'(r) && j_q == RW'(c)) c_d[r*N+c] = mac_sum;
                        j_d = j_q + RW'(1);
                        if (j_q == RW'(N - 1)) begin
                            j_d = '0;
                            i_d = i_q + RW'(1);
                            if (i_q == RW'(N - 1)) begin
                                i_d     = '0;
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_DONE:  state_d = S_RESULT;
                default: state_d = S_LOAD_A;
            endcase
        end
    end

    // state, counters and operand/result storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD_A;
            load_idx_q <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            for (int e = 0; e < NN; e++) begin
                a_q[e] <= '0;
                b_q[e] <= '0;
                c_q[e] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
        end
    end

    matrix_mac_unit #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .en    (mac_en),
        .first (mac_first),
        .a     (a_op),
        .b     (b_op),
        .sum   (mac_sum)
    );

endmodule

// File: tb/tb_matrix_mac_engine.sv
// tb_matrix_mac_engine: scoreboard bench for the N=2 and N=4 matrix engines
module tb_matrix_mac_engine;

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic       clear = 0, load_valid = 0, start = 0;
    logic [3:0] load_data = 0;
    logic [0:0] rd_row = 0, rd_col = 0;
    logic       load_ready, busy, done, result_valid;
    logic [2:0] load_idx;
    logic [8:0] rd_data;
    logic [3:0] rd_digit;

    logic       clear4 = 0, load_valid4 = 0, start4 = 0;
    logic [3:0] load_data4 = 0;
    logic [1:0] rd_row4 = 0, rd_col4 = 0;
    logic       load_ready4, busy4, done4, result_valid4;
    logic [4:0] load_idx4;
    logic [9:0] rd_data4;
    logic [3:0] rd_digit4;

    matrix_mac_engine #(.N(2), .DW(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_idx(load_idx), .start(start), .busy(busy), .done(done),
        .result_valid(result_valid), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .rd_digit(rd_digit)
    );

    matrix_mac_engine #(.N(4), .DW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear4), .load_valid(load_valid4), .load_data(load_data4),
        .load_ready(load_ready4), .load_idx(load_idx4), .start(start4), .busy(busy4), .done(done4),
        .result_valid(result_valid4), .rd_row(rd_row4), .rd_col(rd_col4), .rd_data(rd_data4),
        .rd_digit(rd_digit4)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int exp4_q[$];
    int ma[4];
    int mb[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    // load ma then mb, optionally with bubbles and a stray start at element start_at
    task automatic load2(input bit gaps, input int start_at);
        for (int e = 0; e < 8; e++) begin
            if (gaps) begin
                load_valid = 0;
                repeat ($urandom_range(0, 2)) tick();
            end
            load_valid = 1;
            if (e < 4) load_data = 4'(ma[e]);
            else       load_data = 4'(mb[e-4]);
            start = (e == start_at);
            @(negedge clk);
            n_cmp++;
            if (load_idx !== 3'(e) || load_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL load_step%0d: idx=%0d ready=%b, expected idx=%0d ready=1", e, load_idx, load_ready, e);
            end
            tick();
        end
        load_valid = 0;
        start = 0;
        @(negedge clk);
        n_cmp++;
        if (load_ready !== 1'b0 || load_idx !== 3'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_state: ready=%b idx=%0d busy=%b, expected 0 0 0", load_ready, load_idx, busy);
        end
        tick();
    endtask

    // compare C against the next four scoreboard entries
    task automatic check_c(input string tag);
        int v;
        int dg;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s_empty: scoreboard empty at C[%0d][%0d], got %0d", tag, r, c, rd_data);
                end else begin
                    v = exp_q.pop_front();
                    dg = (v > 9) ? 9 : v;
                    rd_row = 1'(r);
                    rd_col = 1'(c);
                    #1;
                    if (rd_data !== 9'(v) || rd_digit !== 4'(dg)) begin
                        n_bad++;
                        $display("FAIL %s_C%0d%0d: data=%0d digit=%0d, expected data=%0d digit=%0d", tag, r, c, rd_data, rd_digit, v, dg);
                    end
                end
            end
    endtask

    // push expected C, start, track done timing and pulse count, then check C
    task automatic run2(input string tag, input bit poke);
        int first = 0;
        int pulses = 0;
        int s;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                s = 0;
                for (int k = 0; k < 2; k++) s += ma[r*2+k] * mb[k*2+c];
                exp_q.push_back(s);
            end
        start = 1;
        tick();
        start = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            start = poke && cyc >= 2 && cyc <= 4;
            @(negedge clk);
            if (cyc == 1) begin
                n_cmp++;
                if (busy !== 1'b1 || result_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s_busy: busy=%b result_valid=%b, expected 1 0", tag, busy, result_valid);
                end
            end
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) first = cyc;
            end
            tick();
        end
        start = 0;
        n_cmp++;
        if (first != 9 || pulses != 1) begin
            n_bad++;
            $display("FAIL %s_done: first at cycle %0d pulses %0d, expected cycle 9 pulses 1", tag, first, pulses);
        end
        n_cmp++;
        if (result_valid !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_rv: result_valid=%b busy=%b, expected 1 0", tag, result_valid, busy);
        end
        check_c(tag);
    endtask

    task automatic test_reset();
        n_cmp++;
        if (load_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0 || load_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_ctl: ready=%b busy=%b done=%b rv=%b idx=%0d, expected 1 0 0 0 0", load_ready, busy, done, result_valid, load_idx);
        end
        for (int e = 0; e < 4; e++) exp_q.push_back(0);
        check_c("reset");
    endtask

    task automatic test_basic();
        ma = '{1, 2, 3, 4};
        mb = '{5, 6, 7, 8};
        load2(0, -1);
        run2("basic", 0);
    endtask

    task automatic test_identity();
        do_clear();
        ma = '{1, 0, 0, 1};
        mb = '{1, 0, 2, 3};
        load2(0, -1);
        run2("ident", 0);
    endtask

    task automatic test_max2();
        do_clear();
        ma = '{15, 15, 15, 15};
        mb = '{15, 15, 15, 15};
        load2(0, -1);
        run2("max2", 0);
    endtask

    task automatic test_gaps();
        do_clear();
        for (int e = 0; e < 4; e++) begin
            ma[e] = int'($urandom_range(0, 15));
            mb[e] = int'($urandom_range(0, 15));
        end
        load2(1, -1);
        load_valid = 1;
        load_data = 4'hF;
        tick();
        load_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (load_idx !== 3'd0 || load_ready !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL extra_load: idx=%0d ready=%b busy=%b rv=%b, expected 0 0 0 0", load_idx, load_ready, busy, result_valid);
        end
        tick();
        run2("gaps", 0);
    endtask

    task automatic test_start_ignored();
        do_clear();
        ma = '{3, 1, 4, 1};
        mb = '{5, 9, 2, 6};
        load2(0, 5);
        run2("noretrig", 1);
        run2("rerun", 0);
    endtask

    task automatic test_abort();
        int pulses = 0;
        do_clear();
        ma = '{2, 3, 4, 5};
        mb = '{6, 7, 8, 9};
        load2(0, -1);
        start = 1;
        tick();
        start = 0;
        repeat (3) tick();
        clear = 1;
        start = 1;
        load_valid = 1;
        load_data = 4'd7;
        tick();
        clear = 0;
        start = 0;
        load_valid = 0;
        n_cmp++;
        if (load_ready !== 1'b1 || load_idx !== 3'd0 || busy !== 1'b0 || result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_ctl: ready=%b idx=%0d busy=%b rv=%b, expected 1 0 0 0", load_ready, load_idx, busy, result_valid);
        end
        for (int e = 0; e < 4; e++) exp_q.push_back(0);
        check_c("abort");
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses != 0 || load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_done: pulses=%0d ready=%b, expected 0 1", pulses, load_ready);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        for (int e = 0; e < 6; e++) begin
            load_valid = 1;
            load_data = 4'(e + 1);
            tick();
        end
        load_valid = 0;
        #2;
        rst_n = 0;
        #1;
        n_cmp++;
        if (load_idx !== 3'd0 || load_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: idx=%0d ready=%b busy=%b done=%b rv=%b, expected 0 1 0 0 0", load_idx, load_ready, busy, done, result_valid);
        end
        #2;
        rst_n = 1;
        tick();
        ma = '{7, 2, 0, 5};
        mb = '{1, 3, 4, 2};
        load2(0, -1);
        run2("postrst", 0);
    endtask

    task automatic test_max4();
        int first = 0;
        int s;
        int v;
        for (int e = 0; e < 16; e++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += 15 * 15;
            exp4_q.push_back(s);
        end
        for (int e = 0; e < 32; e++) begin
            load_valid4 = 1;
            load_data4 = 4'd15;
            tick();
        end
        load_valid4 = 0;
        start4 = 1;
        tick();
        start4 = 0;
        for (int cyc = 1; cyc <= 100 && first == 0; cyc++) begin
            @(negedge clk);
            if (done4 === 1'b1) first = cyc;
            tick();
        end
        n_cmp++;
        if (first != 65) begin
            n_bad++;
            $display("FAIL max4_done: done at cycle %0d, expected 65", first);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                v = exp4_q.pop_front();
                rd_row4 = 2'(r);
                rd_col4 = 2'(c);
                #1;
                n_cmp++;
                if (rd_data4 !== 10'(v) || rd_digit4 !== 4'd9) begin
                    n_bad++;
                    $display("FAIL max4_C%0d%0d: data=%0d digit=%0d, expected data=%0d digit=9", r, c, rd_data4, rd_digit4, v);
                end
            end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        test_reset();
        rst_n = 1;
        tick();
        test_basic();
        test_identity();
        test_max2();
        test_gaps();
        test_start_ignored();
        test_abort();
        test_async_reset();
        test_max4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
